// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - pixel coordinate and sync bundle from the timing generator to the renderers
interface vga_sync_gen_if #(
  parameter int PIXEL_DISPLAY_BIT = 9
);
  logic [PIXEL_DISPLAY_BIT:0] X;
  logic [PIXEL_DISPLAY_BIT:0] Y;
  logic                       hsync;
  logic                       vsync;
  logic                       video_on;
  logic                       line_tick;
  logic                       frame_tick;

  modport master (
    output X, Y, hsync, vsync, video_on, line_tick, frame_tick
  );

  modport slave (
    input X, Y, hsync, vsync, video_on, line_tick, frame_tick
  );
endinterface

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 pixel timing generator with delayed sync/blank outputs
module vga_sync_gen #(
  parameter int PIXEL_DISPLAY_BIT = 9,
  parameter int H_ACTIVE          = 640,
  parameter int H_FP              = 16,
  parameter int H_SYNC            = 96,
  parameter int H_BP              = 48,
  parameter int V_ACTIVE          = 480,
  parameter int V_FP              = 10,
  parameter int V_SYNC            = 2,
  parameter int V_BP              = 33,
  parameter bit SYNC_ACTIVE       = 1'b0,
  parameter int PIPE_DELAY        = 2
) (
  input  logic           clock_25,
  input  logic           resetn,
  vga_sync_gen_if.master vga
);

  localparam int W       = PIXEL_DISPLAY_BIT + 1;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [W-1:0] coord_t;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS    = coord_t'(V_ACTIVE);

  // The delay line must hold between one and four stages
  if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_pipe_delay
    $error("vga_sync_gen: PIPE_DELAY must be in 1..4");
  end

  coord_t                x_q, x_d;
  coord_t                y_q, y_d;
  logic                  line_tick_q, line_tick_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
  logic [PIPE_DELAY-1:0] vo_pipe_q, vo_pipe_d;
  logic                  hs_raw, vs_raw, vo_raw;

  // Next coordinates, ticks registered to coincide with the last pixel, and undelayed decode
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
    end else begin
      x_d = x_q + coord_t'(1);
    end
    line_tick_d  = (x_d == H_LAST);
    frame_tick_d = line_tick_d && (y_d == V_LAST);

    hs_raw = ((x_q >= HS_START) && (x_q <= HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_raw = ((y_q >= VS_START) && (y_q <= VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vo_raw = (x_q < H_VIS) && (y_q < V_VIS);

    hs_pipe_d    = hs_pipe_q;
    vs_pipe_d    = vs_pipe_q;
    vo_pipe_d    = vo_pipe_q;
    hs_pipe_d[0] = hs_raw;
    vs_pipe_d[0] = vs_raw;
    vo_pipe_d[0] = vo_raw;
    for (int i = 1; i < PIPE_DELAY; i++) begin
      hs_pipe_d[i] = hs_pipe_q[i-1];
      vs_pipe_d[i] = vs_pipe_q[i-1];
      vo_pipe_d[i] = vo_pipe_q[i-1];
    end
  end

  // State registers; reset also flushes the delay line so no stale sync escapes
  always_ff @(posedge clock_25 or negedge resetn) begin
    if (!resetn) begin
      x_q          <= '0;
      y_q          <= '0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      hs_pipe_q    <= {PIPE_DELAY{~SYNC_ACTIVE}};
      vs_pipe_q    <= {PIPE_DELAY{~SYNC_ACTIVE}};
      vo_pipe_q    <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      vo_pipe_q    <= vo_pipe_d;
    end
  end

  assign vga.X          = x_q;
  assign vga.Y          = y_q;
  assign vga.line_tick  = line_tick_q;
  assign vga.frame_tick = frame_tick_q;
  assign vga.hsync      = hs_pipe_q[PIPE_DELAY-1];
  assign vga.vsync      = vs_pipe_q[PIPE_DELAY-1];
  assign vga.video_on   = vo_pipe_q[PIPE_DELAY-1];

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - bench comparing four generator configurations against a cycle-count model
module tb_vga_sync_gen;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;
  int   k;

  // geometry 0 is a shrunken frame so whole frames fit in the run; geometry 1 is the real 640x480 timing
  int g_ha[2] = '{40, 640};
  int g_hf[2] = '{4, 16};
  int g_hs[2] = '{8, 96};
  int g_hb[2] = '{6, 48};
  int g_va[2] = '{20, 480};
  int g_vf[2] = '{2, 10};
  int g_vs[2] = '{2, 2};
  int g_vb[2] = '{3, 33};

  vga_sync_gen_if #(.PIXEL_DISPLAY_BIT(9)) if0 ();
  vga_sync_gen_if #(.PIXEL_DISPLAY_BIT(9)) if1 ();
  vga_sync_gen_if #(.PIXEL_DISPLAY_BIT(9)) if2 ();
  vga_sync_gen_if #(.PIXEL_DISPLAY_BIT(9)) if3 ();

  vga_sync_gen #(
    .PIXEL_DISPLAY_BIT(9), .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_ACTIVE(1'b0), .PIPE_DELAY(2)
  ) u_d2 (.clock_25(clk), .resetn(resetn), .vga(if0));

  vga_sync_gen #(
    .PIXEL_DISPLAY_BIT(9), .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_ACTIVE(1'b0), .PIPE_DELAY(1)
  ) u_d1 (.clock_25(clk), .resetn(resetn), .vga(if1));

  vga_sync_gen #(
    .PIXEL_DISPLAY_BIT(9), .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_ACTIVE(1'b1), .PIPE_DELAY(4)
  ) u_d4 (.clock_25(clk), .resetn(resetn), .vga(if2));

  vga_sync_gen u_full (.clock_25(clk), .resetn(resetn), .vga(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string nm, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, nm, o, e);
    end
  endtask

  // Expected outputs after n clock edges since reset release (n=0 means in or just out of reset)
  task automatic check_inst(input string tag, input int n, input int d, input int g, input bit sa,
                            input logic [9:0] ox, input logic [9:0] oy, input logic ohs,
                            input logic ovs, input logic ovo, input logic olt, input logic oft);
    int ht, vt, pos, ex, ey, px, py;
    logic ehs, evs, evo;
    ht  = g_ha[g] + g_hf[g] + g_hs[g] + g_hb[g];
    vt  = g_va[g] + g_vf[g] + g_vs[g] + g_vb[g];
    pos = n % (ht * vt);
    ex  = pos % ht;
    ey  = pos / ht;
    if (n < d) begin
      ehs = ~sa;
      evs = ~sa;
      evo = 1'b0;
    end else begin
      pos = (n - d) % (ht * vt);
      px  = pos % ht;
      py  = pos / ht;
      ehs = (px >= g_ha[g] + g_hf[g] && px < g_ha[g] + g_hf[g] + g_hs[g]) ? sa : ~sa;
      evs = (py >= g_va[g] + g_vf[g] && py < g_va[g] + g_vf[g] + g_vs[g]) ? sa : ~sa;
      evo = (px < g_ha[g]) && (py < g_va[g]);
    end
    chk(tag, "X", 32'(ox), 32'(ex));
    chk(tag, "Y", 32'(oy), 32'(ey));
    chk(tag, "hsync", 32'(ohs), 32'(ehs));
    chk(tag, "vsync", 32'(ovs), 32'(evs));
    chk(tag, "video_on", 32'(ovo), 32'(evo));
    chk(tag, "line_tick", 32'(olt), 32'(ex == ht - 1));
    chk(tag, "frame_tick", 32'(oft), 32'((ex == ht - 1) && (ey == vt - 1)));
  endtask

  task automatic check_all(input int n);
    check_inst("d2", n, 2, 0, 1'b0, if0.X, if0.Y, if0.hsync, if0.vsync, if0.video_on, if0.line_tick, if0.frame_tick);
    check_inst("d1", n, 1, 0, 1'b0, if1.X, if1.Y, if1.hsync, if1.vsync, if1.video_on, if1.line_tick, if1.frame_tick);
    check_inst("d4", n, 4, 0, 1'b1, if2.X, if2.Y, if2.hsync, if2.vsync, if2.video_on, if2.line_tick, if2.frame_tick);
    check_inst("full", n, 2, 1, 1'b0, if3.X, if3.Y, if3.hsync, if3.vsync, if3.video_on, if3.line_tick, if3.frame_tick);
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
    check_all(k);
  endtask

  initial begin
    int target;
    int small_frame;
    checks      = 0;
    failures    = 0;
    k           = 0;
    small_frame = 58 * 27;
    resetn      = 1'b0;

    // power-on reset held five cycles
    repeat (5) begin
      @(negedge clk);
      check_all(0);
    end
    #1 resetn = 1'b1;

    // two shrunken frames plus two full-size lines
    repeat (3300) step();

    // async resets landing inside the shrunken hsync window, then recovery
    for (int r = 0; r < 3; r++) begin
      target = ((k / small_frame) + 1) * small_frame
               + 58 * int'($urandom_range(1, 25)) + 45 + int'($urandom_range(0, 6));
      while (k < target) step();
      #1 resetn = 1'b0;
      #1 check_all(0);
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        check_all(0);
      end
      #1 resetn = 1'b1;
      k = 0;
      repeat (1700 + $urandom_range(0, 200)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Pixel-timing generator for the 640x480 @ 60 Hz display, clocked by the 25 MHz pixel clock. Produces the X/Y pixel coordinates consumed by the background/HUD renderer and the snake renderer. Also produces hsync, vsync and video_on, delayed by a programmable number of cycles so they line up with the registered renderer and ROM stages downstream. Also produces line and frame strobes for the game-logic tick.

Parameters:
PIXEL_DISPLAY_BIT, 9, MSB index of X/Y (coordinate width = PIXEL_DISPLAY_BIT+1).
H_ACTIVE, 640, visible pixels per line.
H_FP, 16, horizontal front porch (cycles).
H_SYNC, 96, horizontal sync width (cycles).
H_BP, 48, horizontal back porch (cycles).
V_ACTIVE, 480, visible lines per frame.
V_FP, 10, vertical front porch (lines).
V_SYNC, 2, vertical sync width (lines).
V_BP, 33, vertical back porch (lines).
SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = negative polarity).
PIPE_DELAY, 2, cycles of delay of hsync/vsync/video_on relative to X/Y; legal range 1..4.

Ports:
clock_25  input  1  25 MHz pixel clock; all logic on the rising edge.
resetn  input  1  asynchronous active-low reset.
X  output  PIXEL_DISPLAY_BIT+1  horizontal counter, 0..H_TOTAL-1.
Y  output  PIXEL_DISPLAY_BIT+1  vertical counter, 0..V_TOTAL-1.
hsync  output  1  horizontal sync, delayed PIPE_DELAY cycles.
vsync  output  1  vertical sync, delayed PIPE_DELAY cycles.
video_on  output  1  high inside the visible area, delayed PIPE_DELAY cycles.
line_tick  output  1  one-cycle strobe on the last pixel of every line; aligned with X/Y.
frame_tick  output  1  one-cycle strobe on the last pixel of the frame; aligned with X/Y.

Behaviour:
- Frame totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Reset (resetn=0, asynchronous):
  - X=0, Y=0.
  - line_tick=0, frame_tick=0, video_on=0.
  - hsync=vsync=~SYNC_ACTIVE.
  - All delay-pipeline stages are cleared to these inactive values.
- First rising edge after resetn deasserts: X becomes 1, Y stays 0. The counters advance every clock from then on; there is no enable.
- X counter: increments by 1. At X==H_TOTAL-1 it wraps to 0 on the next edge.
- Y counter: increments only on the edge where X wraps. At Y==V_TOTAL-1 with X==H_TOTAL-1 it wraps to 0.
- Undelayed decode, computed from the current X/Y:
  - hs_raw = SYNC_ACTIVE when H_ACTIVE+H_FP <= X <= H_ACTIVE+H_FP+H_SYNC-1 (656..751 by default).
  - vs_raw = SYNC_ACTIVE when V_ACTIVE+V_FP <= Y <= V_ACTIVE+V_FP+V_SYNC-1 (490..491 by default).
  - vo_raw = (X < H_ACTIVE) && (Y < V_ACTIVE).
- Delay: hs_raw, vs_raw and vo_raw each pass through a shift register of exactly PIPE_DELAY flops. The output at cycle t equals the decode of the X/Y present at cycle t-PIPE_DELAY. All three outputs come straight from flops, so they are glitch-free.
- line_tick = 1 exactly when X==H_TOTAL-1. It is registered so it is high during the same cycle X shows H_TOTAL-1.
- frame_tick = 1 exactly when X==H_TOTAL-1 && Y==V_TOTAL-1. It always coincides with a line_tick.
- Counters never exceed their wrap values. Arithmetic is unsigned, at coordinate width; the compare constants fit in that width.
- Reset mid-frame: all outputs return to their reset values immediately, and the next frame restarts from (0,0). The stale delay-pipeline contents are discarded and are never emitted after reset.
- Illegal PIPE_DELAY (0 or >4) is a synthesis-time error, raised by a generate-time check.

Test Plan:
- Reset: hold resetn=0 for 5 cycles, release → X=0/Y=0 and hsync=vsync=1, video_on=0 during reset; X=1 one edge after release.
- Horizontal timing, PIPE_DELAY=2: track one line → hsync is 0 on exactly the 96 cycles during which X shows 658..753, and video_on is 1 while X shows 2..641.
- Line wrap: at X=799 → line_tick=1 for 1 cycle; next cycle X=0 and Y increments by 1; 800 cycles between line_ticks.
- Vertical/frame: run a full frame → vsync=0 for exactly 1600 cycles (Y=490..491, shifted 2 cycles); frame_tick=1 only at (799,524); next cycle (0,0); 420000 cycles between frame_ticks.
- Delay sweep: PIPE_DELAY=1 and 4 → first hsync assertion when X shows 657 and 660 respectively.
- Reset mid-frame: assert resetn=0 at X=700, Y=300 (hsync active in pipeline) → hsync returns to 1 immediately; after release no residual sync pulse is emitted before X reaches 656+PIPE_DELAY.
